// File: rtl/jk_bank_sequencer.sv
// -----------------------------------------------------------------------------
// jk_bank_sequencer
//   A bank of WIDTH JK bit cells driven by a small command sequencer. A command
//   (op, data, repeat count) is accepted in IDLE, its J/K drive pattern is
//   applied for cmd_count+1 cycles in RUN, and a one-cycle DONE follows.
//
// Parameters
//   WIDTH     : number of JK cells in the bank (>= 2)
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset
//   cmd_valid : command request
//   cmd_ready : high in IDLE, command accepted on cmd_valid & cmd_ready
//   cmd_op    : operation code (HOLD/SET/CLEAR/TOGGLE/LOAD/UP/DOWN/reserved)
//   cmd_data  : bit mask or load value
//   cmd_count : repeat count, operation applied cmd_count+1 times
//   j, k      : J and K drive of each cell
//   q         : bank state
//   busy      : high in RUN and DONE
//   done      : one-cycle completion pulse
//   err       : pulses with done when the completed command used op 111
// -----------------------------------------------------------------------------
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_count,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_SET    = 3'b001,
    OP_CLEAR  = 3'b010,
    OP_TOGGLE = 3'b011,
    OP_LOAD   = 3'b100,
    OP_UP     = 3'b101,
    OP_DOWN   = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic             accept;
  logic [WIDTH-1:0] up_en;   // cell i toggles when all lower bits are 1
  logic [WIDTH-1:0] dn_en;   // cell i toggles when all lower bits are 0

  // Counter toggle enables: bit 0 always toggles, bit i toggles on the
  // AND-reduction of the bits below it (ripple-carry / ripple-borrow).
  assign up_en[0] = 1'b1;
  assign dn_en[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_cnt_en
    assign up_en[gi] = &q_q[gi-1:0];
    assign dn_en[gi] = &(~q_q[gi-1:0]);
  end

  assign accept = cmd_valid && (state_q == S_IDLE);

  // Next-state, latch-on-accept and J/K drive.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    j       = '0;
    k       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          op_d    = op_e'(cmd_op);
          data_d  = cmd_data;
          cnt_d   = cmd_count;
          err_d   = (cmd_op == OP_RSVD);
        end
      end
      S_RUN: begin
        unique case (op_q)
          OP_SET:    begin j = data_q; k = '0;      end
          OP_CLEAR:  begin j = '0;     k = data_q;  end
          OP_TOGGLE: begin j = data_q; k = data_q;  end
          OP_LOAD:   begin j = data_q; k = ~data_q; end
          OP_UP:     begin j = up_en;  k = up_en;   end
          OP_DOWN:   begin j = dn_en;  k = dn_en;   end
          default:   begin j = '0;     k = '0;      end  // HOLD and reserved
        endcase
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // JK rule per cell; with j=k=0 outside RUN the bank simply holds.
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      q_q     <= q_d;
    end
  end

  assign q         = q_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = done && err_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_sequencer
//   Directed bench for jk_bank_sequencer (WIDTH=4). Inputs change and outputs
//   are sampled 1ns after each rising edge. Status vectors are packed as
//   {cmd_ready, busy, done, err}.
// -----------------------------------------------------------------------------
module tb_jk_bank_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [3:0]   cmd_count;
  logic [W-1:0] j, k, q;
  logic         busy, done, err;

  int checks;
  int failures;

  jk_bank_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .j         (j),
    .k         (k),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] stat();
    return {cmd_ready, busy, done, err};
  endfunction

  // Present a command and let it be accepted; returns in the first RUN cycle.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d,
                       input logic [3:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Run a command to completion and return in the following IDLE cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d,
                         input logic [3:0] cnt);
    int n;
    issue(op, d, cnt);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL run_cmd_timeout: done=%b after %0d cycles, required done=1", done, n);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b1;       // must be ignored while in reset
    cmd_op    = 3'b001;
    cmd_data  = 4'b1111;
    cmd_count = 4'd0;
    tick();
    tick();
    checks++;
    if (stat() !== 4'b1000) begin
      failures++;
      $display("FAIL reset_status: got %b required 1000", stat());
    end
    checks++;
    if ({q, j, k} !== 12'h000) begin
      failures++;
      $display("FAIL reset_qjk: got q=%b j=%b k=%b required all zero", q, j, k);
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_load();
    issue(3'b100, 4'b1010, 4'd0);
    cmd_data = 4'b0110;     // changes after acceptance must not matter
    cmd_op   = 3'b011;
    checks++;
    if ({stat(), j, k} !== {4'b0100, 4'b1010, 4'b0101}) begin
      failures++;
      $display("FAIL load_run: got stat=%b j=%b k=%b required 0100 1010 0101", stat(), j, k);
    end
    tick();
    checks++;
    if ({stat(), q, j, k} !== {4'b0110, 4'b1010, 8'h00}) begin
      failures++;
      $display("FAIL load_done: got stat=%b q=%b j=%b k=%b required 0110 1010 0000 0000", stat(), q, j, k);
    end
    tick();
    checks++;
    if ({stat(), q} !== {4'b1000, 4'b1010}) begin
      failures++;
      $display("FAIL load_idle: got stat=%b q=%b required 1000 1010", stat(), q);
    end
  endtask

  task automatic test_up_wrap();
    int bad;
    run_cmd(3'b100, 4'b0000, 4'd0);
    issue(3'b101, 4'b0000, 4'd15);
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (q !== 4'(i) || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL up_sequence: %0d cycles off the 1..15 count, last q=%b done=%b required q=1111 done=0", bad, q, done);
    end
    tick();                 // 17 cycles after acceptance
    checks++;
    if ({stat(), q} !== {4'b0110, 4'b0000}) begin
      failures++;
      $display("FAIL up_wrap: got stat=%b q=%b required 0110 0000", stat(), q);
    end
    tick();
  endtask

  task automatic test_toggle_clear();
    run_cmd(3'b100, 4'b0101, 4'd0);
    issue(3'b011, 4'b1100, 4'd1);
    tick();
    checks++;
    if ({q, done} !== {4'b1001, 1'b0}) begin
      failures++;
      $display("FAIL toggle_1: got q=%b done=%b required 1001 0", q, done);
    end
    tick();
    checks++;
    if ({q, done} !== {4'b0101, 1'b1}) begin
      failures++;
      $display("FAIL toggle_2: got q=%b done=%b required 0101 1", q, done);
    end
    tick();
    issue(3'b010, 4'b0100, 4'd0);
    tick();
    checks++;
    if ({q, done} !== {4'b0001, 1'b1}) begin
      failures++;
      $display("FAIL clear: got q=%b done=%b required 0001 1", q, done);
    end
    tick();
  endtask

  task automatic test_down_wrap();
    logic [W-1:0] exp_q [3];
    exp_q = '{4'b1111, 4'b1110, 4'b1101};
    run_cmd(3'b100, 4'b0000, 4'd0);
    issue(3'b110, 4'b0000, 4'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({q, done} !== {exp_q[i], (i == 2)}) begin
        failures++;
        $display("FAIL down_%0d: got q=%b done=%b required %b %b", i, q, done, exp_q[i], (i == 2));
      end
    end
    tick();
  endtask

  task automatic test_reserved();
    int bad;
    // q is 1101 from the DOWN test
    issue(3'b111, 4'b1111, 4'd3);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (q !== 4'b1101 || done !== 1'b0 || err !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rsvd_run: %0d run cycles wrong, q=%b done=%b err=%b required 1101 0 0", bad, q, done, err);
    end
    checks++;
    if ({stat(), q} !== {4'b0111, 4'b1101}) begin
      failures++;
      $display("FAIL rsvd_done: got stat=%b q=%b required 0111 1101", stat(), q);
    end
    tick();
    checks++;
    if (stat() !== 4'b1000) begin
      failures++;
      $display("FAIL rsvd_after: got stat=%b required 1000", stat());
    end
    // a following HOLD must complete without err
    issue(3'b000, 4'b1111, 4'd0);
    tick();
    checks++;
    if ({stat(), q} !== {4'b0110, 4'b1101}) begin
      failures++;
      $display("FAIL err_cleared: got stat=%b q=%b required 0110 1101", stat(), q);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_s [5];
    exp_s = '{4'b0100, 4'b0110, 4'b1000, 4'b0100, 4'b0110};
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 4'b0010;
    cmd_count = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) cmd_valid = 1'b0;
      checks++;
      if (stat() !== exp_s[i]) begin
        failures++;
        $display("FAIL b2b_%0d: got stat=%b required %b", i, stat(), exp_s[i]);
      end
    end
    checks++;
    if (q !== 4'b1111) begin
      failures++;
      $display("FAIL b2b_q: got q=%b required 1111", q);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    run_cmd(3'b100, 4'b0000, 4'd0);
    issue(3'b101, 4'b0000, 4'd10);   // now in RUN cycle 1
    tick();                          // RUN cycle 2
    tick();                          // RUN cycle 3
    checks++;
    if ({stat(), q} !== {4'b0100, 4'b0010}) begin
      failures++;
      $display("FAIL up_before_rst: got stat=%b q=%b required 0100 0010", stat(), q);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({stat(), q} !== {4'b1000, 4'b0000}) begin
      failures++;
      $display("FAIL mid_rst: got stat=%b q=%b required 1000 0000", stat(), q);
    end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0 || q !== 4'b0000) begin
      failures++;
      $display("FAIL mid_rst_nodone: got %0d done pulses q=%b required 0 0000", pulses, q);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = '0;
    cmd_count = '0;
    #1;
    test_reset();
    test_load();
    test_up_wrap();
    test_toggle_clear();
    test_down_wrap();
    test_reserved();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, the number of JK bit cells in the bank (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: the command request.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 3 bits: the operation code.
REQ-007 The block SHALL have port cmd_data, input, WIDTH bits: the bit mask or load value.
REQ-008 The block SHALL have port cmd_count, input, 4 bits: the repeat count; the operation is applied cmd_count+1 times.
REQ-009 The block SHALL have port j, output, WIDTH bits: the J drive of each cell.
REQ-010 The block SHALL have port k, output, WIDTH bits: the K drive of each cell.
REQ-011 The block SHALL have port q, output, WIDTH bits: the bank state.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-014 The block SHALL have port err, output, 1 bit: pulses together with done when the completed command used the reserved op.

Function
REQ-015 Each cell SHALL update per JK rule q_next[i] = (j[i] & ~q[i]) | (~k[i] & q[i]), on every clk edge, in every state.
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
- IDLE -> RUN on cmd_valid & cmd_ready.
- RUN -> DONE on the edge where the remaining count equals 0.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 cmd_ready SHALL equal (state == IDLE); cmd_op, cmd_data and cmd_count SHALL be latched at acceptance, and input changes after acceptance SHALL have no effect.
REQ-018 In IDLE and DONE, j and k SHALL be all-zero, so q holds.
REQ-019 In RUN, j and k SHALL be combinational from the latched op, latched data (d) and the current q:
- op 000 HOLD: j=0, k=0.
- op 001 SET: j=d, k=0.
- op 010 CLEAR: j=0, k=d.
- op 011 TOGGLE: j=d, k=d.
- op 100 LOAD: j=d, k=~d.
- op 101 UP: j[i]=k[i]=&q[i-1:0], with j[0]=k[0]=1.
- op 110 DOWN: j[i]=k[i]=&~q[i-1:0], with j[0]=k[0]=1.
- op 111 reserved: behaves as HOLD and sets an internal err flag.
REQ-020 The remaining-count register SHALL load cmd_count at acceptance and decrement once per RUN cycle.
REQ-021 Timing for a command accepted at edge N:
- The op SHALL be applied in cycles N+1 through N+1+cmd_count.
- done SHALL be high only in cycle N+2+cmd_count.
- busy SHALL be high from cycle N+1 through N+2+cmd_count.
- cmd_ready SHALL return high in cycle N+3+cmd_count.
REQ-022 UP SHALL wrap from all-ones to zero, and DOWN SHALL wrap from zero to all-ones, without error.
REQ-023 A cmd_valid held high continuously SHALL yield back-to-back commands with exactly one DONE cycle and one IDLE cycle between them.
REQ-024 err SHALL be high only in the DONE cycle of a reserved-op command; the internal err flag SHALL clear on the next acceptance.

Reset
REQ-025 When rst_n=0 at a clk edge, the following SHALL hold after that edge:
- state=IDLE and q=0.
- The latched op, data and count registers = 0, and the err flag = 0.
- j=0, k=0, busy=0, done=0, err=0, cmd_ready=1.
REQ-026 Reset SHALL take priority over command acceptance and over RUN progress; a reset mid-RUN SHALL abort the command with no done pulse.

Verification
REQ-027 The bench SHALL cover: reset, then LOAD d=1010 count=0 -> q=1010 one edge after acceptance, and done high in the next cycle.
REQ-028 The bench SHALL cover: q=0, UP count=15 (WIDTH=4) -> q passes through 1..15 and ends at 0000 (wrap), with done high 17 cycles after acceptance.
REQ-029 The bench SHALL cover: q=0101, TOGGLE d=1100 count=1 -> q goes 1001 then 0101; then CLEAR d=0100 -> q=0001.
REQ-030 The bench SHALL cover: q=0000, DOWN count=2 -> q goes 1111, 1110, 1101.
REQ-031 The bench SHALL cover: reserved op 111 count=3 -> q unchanged, and err=1 and done=1 in the same single cycle.
REQ-032 The bench SHALL cover: rst_n=0 during cycle 3 of an UP with count=10 -> q=0, busy=0, no done pulse, cmd_ready=1 on the next cycle.
